vga_frame_reader: RTL and testbench
===================================

# vga_frame_reader

Consumer end of the VGA-side asynchronous FIFO: runs in the VGA pixel clock domain, generates 640x480@60 Hz timing, pops one RGB565 word per active pixel, and drives the VGA pins. The SDRAM arbiter refills this FIFO in 512-word bursts. Streaming starts on a frame boundary only, so the 307200 words of each SDRAM frame (addresses 0..599 × 512) land on pixels (0,0)..(639,479) in raster order. An underflow is flagged and the affected pixel is blanked; the reader never re-synchronises.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- clk  in  1  pixel clock, 25 MHz (FIFO read clock)
- rst_n  in  1  asynchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag, synchronous to clk
- fifo_data  in  16  FIFO read data, valid the cycle after fifo_rd is sampled high
- fifo_rd  out  1  FIFO pop strobe
- underflow_clr  in  1  synchronous clear of underflow
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_de  out  1  active-video qualifier
- vga_r  out  5  red = fifo_data[15:11]
- vga_g  out  6  green = fifo_data[10:5]
- vga_b  out  5  blue = fifo_data[4:0]
- frame_start  out  1  one-clock pulse aligned with the first pixel output of each frame (STREAM only)
- underflow  out  1  sticky: an active pixel found the FIFO empty while streaming

## Operation
- **Counters**
  - h_cnt counts 0..H_total-1; H_total = sum of the four H parameters = 800.
  - v_cnt counts 0..V_total-1; V_total = 525. It advances when h_cnt wraps.
  - Both wrap to 0 together at (799,524).
  - Both run freely from reset, in either state.
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- **FSM**
  - IDLE (reset state) → STREAM when fifo_empty == 0 during the cycle where h_cnt == 799 && v_cnt == 524. Otherwise stay in IDLE.
  - STREAM is held until reset; there is no exit on underflow.
- **FIFO pop**
  - fifo_rd = (state == STREAM) && active && !fifo_empty. It is decoded from registered state and counters plus the fifo_empty input.
  - fifo_rd is never high while fifo_empty is high.
- **Underflow**
  - Condition: state == STREAM && active && fifo_empty.
  - That pixel outputs RGB 0 with vga_de = 1.
  - The underflow flag sets on the next edge.
  - Later pixels continue to pop normally, so the image is shifted; this is accepted.
- **Underflow clear**
  - underflow_clr clears the flag. A set condition in the same cycle wins.
- **IDLE output**
  - Syncs toggle normally, vga_de = 0, RGB = 0, fifo_rd = 0.

## Timing
- **Output register stage:** all VGA outputs are registered, one clock after the counters.
  - vga_hsync is low at cycle t+1 iff h_cnt(t) ∈ [656, 751].
  - vga_vsync is low at cycle t+1 iff v_cnt(t) ∈ [490, 491].
  - vga_de(t+1) = active(t).
  - RGB(t+1) = fifo_data if fifo_rd(t) was high, else 0.
- **Pop-to-pixel latency:** 1 clock.
- **Pops per frame:** 307200 when the FIFO never underflows.
- **frame_start:** high at t+1 when state(t) == STREAM and h_cnt(t) == 0 && v_cnt(t) == 0.
- **Reset values** (asynchronous, while rst_n is low):
  - Counters and state: h_cnt = 0, v_cnt = 0, state = IDLE.
  - Outputs: vga_hsync = 1, vga_vsync = 1, vga_de = 0, RGB = 0, fifo_rd = 0, frame_start = 0, underflow = 0.
- **Reset mid-frame:** all of the above return to reset values immediately. Streaming resumes only at the next frame boundary with the FIFO non-empty.

## Test plan
- **Reset idle:** hold rst_n = 0 for 10 clocks with FIFO non-empty → fifo_rd = 0, vga_hsync = 1, vga_vsync = 1, vga_de = 0, underflow = 0.
- **Start alignment:** release reset with FIFO empty, then make it non-empty at h = 300, v = 10 of frame 0 →
  - no pop during frame 0;
  - first fifo_rd at (0,0) of frame 1;
  - frame_start and vga_de rise one clock later, with RGB = first word.
- **Full frame:** keep the FIFO non-empty with an incrementing pattern 0x0000.. →
  - exactly 307200 pops per frame;
  - pixel (639,479) shows word 307199 mod 65536;
  - hsync low for 96 clocks starting at h = 656 (+1 clock output delay);
  - vsync low for 2 lines at v = 490.
- **Underflow:** force fifo_empty = 1 for 3 active clocks mid-line in STREAM →
  - fifo_rd = 0 for those clocks;
  - 3 pixels with vga_de = 1 and RGB = 0;
  - underflow = 1 and held;
  - underflow_clr pulse → 0.
- **Porch read-guard:** FIFO non-empty throughout blanking (h ≥ 640 or v ≥ 480) → fifo_rd = 0 and vga_de = 0 in all blanking cycles.
- **Mid-frame reset:** assert rst_n = 0 at h = 100, v = 200 in STREAM → outputs return to reset values that cycle; the next pop occurs at (0,0) of the following frame.

Source files
------------

// File: rtl/vga_frame_reader_if.sv
// FIFO read-side bundle between the VGA async FIFO and its pixel-clock consumer.
// The master is the reader, the slave is the FIFO.
interface vga_frame_reader_if;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_rd;

    modport master (input fifo_empty, input fifo_data, output fifo_rd);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd);
endinterface

// File: rtl/vga_frame_reader.sv
// VGA timing generator and FIFO consumer: pops one RGB565 word per active pixel
// once streaming has locked to a frame boundary, and flags underflow.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vga_frame_reader_if.master       fifo,
    input  logic                     underflow_clr,
    output logic                     vga_hsync,
    output logic                     vga_vsync,
    output logic                     vga_de,
    output logic [4:0]               vga_r,
    output logic [5:0]               vga_g,
    output logic [4:0]               vga_b,
    output logic                     frame_start,
    output logic                     underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          pop_q, pop_d;
    logic          frame_start_q, frame_start_d;
    logic          underflow_q, underflow_d;

    logic h_end, v_end, active, streaming, starve;

    always_comb begin
        h_end     = (h_cnt_q == H_LAST_C);
        v_end     = (v_cnt_q == V_LAST_C);
        active    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        streaming = (state_q == STREAM);

        h_cnt_d = h_end ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_end) v_cnt_d = v_end ? '0 : v_cnt_q + 1'b1;

        // Lock only on the last clock of a frame so word 0 lands on pixel (0,0).
        state_d = state_q;
        if (state_q == IDLE && h_end && v_end && !fifo.fifo_empty) state_d = STREAM;

        pop_d  = streaming && active && !fifo.fifo_empty;
        starve = streaming && active && fifo.fifo_empty;

        hsync_d       = !((h_cnt_q >= HS_BEG_C) && (h_cnt_q <= HS_END_C));
        vsync_d       = !((v_cnt_q >= VS_BEG_C) && (v_cnt_q <= VS_END_C));
        de_d          = streaming && active;
        frame_start_d = streaming && (h_cnt_q == '0) && (v_cnt_q == '0);
        underflow_d   = starve || (underflow_q && !underflow_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            pop_q         <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pop_q         <= pop_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign fifo.fifo_rd = pop_d;

    // The FIFO's own output register supplies the word in the cycle after the pop,
    // so the colour is gated by the registered pop rather than re-registered here.
    assign vga_r = pop_q ? fifo.fifo_data[15:11] : '0;
    assign vga_g = pop_q ? fifo.fifo_data[10:5]  : '0;
    assign vga_b = pop_q ? fifo.fifo_data[4:0]   : '0;

    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_de      = de_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed + randomized bench for vga_frame_reader using scaled-down timing and a
// cycle-count based reference model of raster position, streaming and pops.
module tb_vga_frame_reader;
    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int MEM_N = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       underflow_clr = 1'b0;
    logic       vga_hsync, vga_vsync, vga_de, frame_start, underflow;
    logic [4:0] vga_r, vga_b;
    logic [5:0] vga_g;

    vga_frame_reader_if bus ();

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fifo(bus.master), .underflow_clr(underflow_clr),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .underflow(underflow)
    );

    always #20 clk = ~clk;

    logic [15:0] mem [MEM_N];
    int rd_ptr = 0;

    // FIFO read side: a popped word appears on fifo_data the following cycle.
    initial bus.fifo_data = 16'h0;
    always @(posedge clk) begin
        if (bus.fifo_rd === 1'b1) begin
            bus.fifo_data <= mem[rd_ptr % MEM_N];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int passed = 0, total = 0;
    int n = 0, exp_ptr = 0;
    bit streaming = 0, uf_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"},    {31'd0, bus.fifo_rd}, 0);
        chk({tag, "_hs"},    {31'd0, vga_hsync}, 1);
        chk({tag, "_vs"},    {31'd0, vga_vsync}, 1);
        chk({tag, "_de"},    {31'd0, vga_de}, 0);
        chk({tag, "_rgb"},   {16'd0, vga_r, vga_g, vga_b}, 0);
        chk({tag, "_fs"},    {31'd0, frame_start}, 0);
        chk({tag, "_uf"},    {31'd0, underflow}, 0);
    endtask

    // One pixel clock: drive inputs at the falling edge, check the pop strobe,
    // then check registered outputs just after the rising edge.
    task automatic step(input bit emp, input bit clr);
        int h, v;
        bit act, erd, set_uf;
        logic [15:0] exp_rgb;
        bus.fifo_empty = emp;
        underflow_clr  = clr;
        h   = n % HT;
        v   = (n / HT) % VT;
        act = (h < HA) && (v < VA);
        erd = streaming && act && !emp;
        #1;
        chk("fifo_rd", {31'd0, bus.fifo_rd}, {31'd0, erd});
        exp_rgb = erd ? mem[exp_ptr % MEM_N] : 16'h0;
        if (erd) exp_ptr++;
        set_uf = streaming && act && emp;
        uf_exp = set_uf || (uf_exp && !clr);
        @(posedge clk);
        #1;
        chk("hsync", {31'd0, vga_hsync}, {31'd0, !(h >= HA + HFP && h < HA + HFP + HS)});
        chk("vsync", {31'd0, vga_vsync}, {31'd0, !(v >= VA + VFP && v < VA + VFP + VS)});
        chk("de", {31'd0, vga_de}, {31'd0, streaming && act});
        chk("rgb", {16'd0, vga_r, vga_g, vga_b}, {16'd0, exp_rgb});
        chk("frame_start", {31'd0, frame_start}, {31'd0, streaming && h == 0 && v == 0});
        chk("underflow", {31'd0, underflow}, {31'd0, uf_exp});
        if (!streaming && !emp && h == HT - 1 && v == VT - 1) streaming = 1;
        n++;
        @(negedge clk);
    endtask

    initial begin
        int p0;
        for (int i = 0; i < MEM_N; i++) mem[i] = (i < 512) ? 16'(i) : 16'($urandom);
        bus.fifo_empty = 1'b0;

        // Reset held with a non-empty FIFO: nothing pops, outputs idle.
        repeat (10) begin
            @(negedge clk);
            #1;
            chk_reset_outputs("reset_idle");
        end

        // Start alignment: FIFO fills mid frame 0; first pop at (0,0) of frame 1.
        rst_n = 1'b1;
        while (n < 3 * FT) begin
            if (n == FT)     chk("frame0_pops", rd_ptr, 0);
            if (n == 2 * FT) chk("frame1_pops", rd_ptr, HA * VA);
            step(n < 2 * HT + 12, 1'b0);
        end
        chk("frame2_pops", rd_ptr, 2 * HA * VA);

        // Three starved active pixels mid-line, then a clear.
        while (n < 4 * FT) step(((n / HT) % VT == 3) && (n % HT >= 5) && (n % HT <= 7), 1'b0);
        chk("uf_held", {31'd0, underflow}, 1);
        step(1'b0, 1'b1);
        chk("uf_cleared", {31'd0, underflow}, 0);

        // Set and clear in the same cycle: set wins.
        while (n < 5 * FT) step(n % HT == 3 && (n / HT) % VT == 2, n % HT == 3 && (n / HT) % VT == 2);

        // Random starvation and clear pulses.
        while (n < 7 * FT) step($urandom_range(7) == 0, $urandom_range(15) == 0);

        // Mid-frame reset while streaming.
        while (n < 7 * FT + 3 * HT + 5) step(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        streaming = 0;
        uf_exp = 0;
        p0 = rd_ptr;
        while (n < 2 * FT) begin
            if (n == FT) chk("post_reset_frame0_pops", rd_ptr, p0);
            step(1'b0, 1'b0);
        end
        chk("post_reset_frame1_pops", rd_ptr, p0 + HA * VA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
